// File: rtl/mux_bus_arbiter.sv
// mux_bus_arbiter
// Round-robin arbiter that owns the select input of a shared 16-bit,
// 11-input mux. It grants one requester at a time, hands over back-to-back
// when the owner releases, and drives the mux select (controle) with the
// owner's index.
//
// Optional feature macro: MUX_ARB_TIMEOUT_EN
//   defined   : an owner holding the path for HOLD_MAX cycles is revoked in
//               favour of the next circular requester; revoke pulses for the
//               handover cycle.
//   undefined : no hold counter is built, revoke is tied low and an owner keeps
//               the grant for as long as it requests.

module mux_bus_arbiter #(
    parameter int N_REQ    = 11,
    parameter int SEL_W    = 4,
    parameter int HOLD_MAX = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] controle,
    output logic             busy,
    output logic             revoke
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Highest requester index; the pointer parks here after reset so that
    // index 0 is first in line.
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_REQ - 1);

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Circular scan: first set bit of rq starting at position start,
    // wrapping from N_REQ-1 back to 0. Returns {found, index}.
    function automatic logic [SEL_W:0] f_rr_scan(
        input logic [N_REQ-1:0] rq,
        input logic [SEL_W-1:0] start
    );
        logic             found;
        logic [SEL_W-1:0] idx;
        int               pos;
        found = 1'b0;
        idx   = {SEL_W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            pos = int'(start) + i;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end else begin
                pos = pos;
            end
            if (!found && rq[pos]) begin
                found = 1'b1;
                idx   = pos[SEL_W-1:0];
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    // One-hot decode of a requester index into a grant vector.
    function automatic logic [N_REQ-1:0] f_onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v = {N_REQ{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            v[i] = (idx == SEL_W'(i));
        end
        return v;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [N_REQ-1:0]   r_grant;
    logic [SEL_W-1:0]   r_controle;
    logic [SEL_W-1:0]   r_last;
    logic               r_busy;

    // ------------------------------------------------------------------
    // Arbitration datapath
    // ------------------------------------------------------------------
    logic [SEL_W-1:0]   w_start;
    logic [N_REQ-1:0]   w_scan_req;
    logic [SEL_W:0]     w_scan;
    logic               w_found;
    logic [SEL_W-1:0]   w_idx;
    logic               w_owner_req;
    logic               w_hold_expired;
    logic               w_load;
    logic               w_release;
    logic               w_timeout;

    // The current owner is never a candidate; in IDLE r_grant is zero so
    // every request competes. While granted, r_last equals the owner, so
    // scanning from r_last+1 is the same as scanning from owner+1.
    assign w_scan_req  = req & ~r_grant;
    assign w_owner_req = |(req & r_grant);
    assign w_scan      = f_rr_scan(w_scan_req, w_start);
    assign w_found     = w_scan[SEL_W];
    assign w_idx       = w_scan[SEL_W-1:0];

    // Scan start: one past the last winner, wrapping at N_REQ-1.
    always_comb begin
        w_start = {SEL_W{1'b0}};
        if (r_last >= LAST_IDX) begin
            w_start = {SEL_W{1'b0}};
        end else begin
            w_start = r_last + SEL_W'(1);
        end
    end

    // Decide what happens at the next edge: load a new owner, release to
    // idle, or keep the current state.
    always_comb begin
        w_load    = 1'b0;
        w_release = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_load = 1'b1;
                end else begin
                    w_release = 1'b1;
                end
            end
            ST_GRANT: begin
                if (w_owner_req) begin
                    // Owner still wants the path; only a hold timeout with
                    // someone else waiting can take it away.
                    if (w_hold_expired && w_found) begin
                        w_load    = 1'b1;
                        w_timeout = 1'b1;
                    end else begin
                        w_load = 1'b0;
                    end
                end else begin
                    // Owner released: hand over with no gap, or go idle.
                    if (w_found) begin
                        w_load = 1'b1;
                    end else begin
                        w_release = 1'b1;
                    end
                end
            end
            default: begin
                w_release = 1'b1;
            end
        endcase
    end

    // Arbiter FSM with registered grant, select and busy outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_grant    <= {N_REQ{1'b0}};
            r_controle <= {SEL_W{1'b0}};
            r_busy     <= 1'b0;
            r_last     <= LAST_IDX;
        end else if (w_load) begin
            r_state    <= ST_GRANT;
            r_grant    <= f_onehot(w_idx);
            r_controle <= w_idx;
            r_busy     <= 1'b1;
            r_last     <= w_idx;
        end else if (w_release) begin
            // controle keeps its value so the mux output does not move.
            r_state    <= ST_IDLE;
            r_grant    <= {N_REQ{1'b0}};
            r_busy     <= 1'b0;
        end else begin
            r_state    <= r_state;
            r_grant    <= r_grant;
            r_controle <= r_controle;
            r_busy     <= r_busy;
            r_last     <= r_last;
        end
    end

`ifdef MUX_ARB_TIMEOUT_EN
    localparam int HC_W = $clog2(HOLD_MAX);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_MAX - 1);

    logic [HC_W-1:0] r_hold_cnt;
    logic            r_revoke;

    assign w_hold_expired = (r_hold_cnt == HOLD_LAST);

    // Hold-time counter per ownership and one-cycle revoke pulse on a
    // forced handover. With nobody waiting the counter simply wraps.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hold_cnt <= {HC_W{1'b0}};
            r_revoke   <= 1'b0;
        end else if (w_load) begin
            r_hold_cnt <= {HC_W{1'b0}};
            r_revoke   <= w_timeout;
        end else if (r_state == ST_GRANT) begin
            if (w_hold_expired) begin
                r_hold_cnt <= {HC_W{1'b0}};
            end else begin
                r_hold_cnt <= r_hold_cnt + HC_W'(1);
            end
            r_revoke <= 1'b0;
        end else begin
            r_hold_cnt <= {HC_W{1'b0}};
            r_revoke   <= 1'b0;
        end
    end

    assign revoke = r_revoke;
`else
    assign w_hold_expired = 1'b0;
    assign revoke         = 1'b0;
`endif

    assign grant    = r_grant;
    assign controle = r_controle;
    assign busy     = r_busy;

endmodule

// File: tb/tb_mux_bus_arbiter.sv
// Testbench for mux_bus_arbiter: a table of single-cycle vectors plus
// hand-written multi-cycle sequences. Each step pushes its expected outputs
// to a scoreboard queue; they are popped and compared after the edge.
// The timeout sequences follow MUX_ARB_TIMEOUT_EN when it is defined.

module tb_mux_bus_arbiter;

    localparam int N  = 11;
    localparam int SW = 4;
    localparam int HM = 4;

    logic          clock;
    logic          reset;
    logic [N-1:0]  req;
    logic [N-1:0]  grant;
    logic [SW-1:0] controle;
    logic          busy;
    logic          revoke;

    int checks = 0;
    int errors = 0;
    int stepno = 0;

    typedef struct {
        logic          rst;
        logic [N-1:0]  req;
        logic [N-1:0]  grant;
        logic [SW-1:0] ctl;
        logic          busy;
    } vec_t;

    typedef struct {
        logic [N-1:0]  grant;
        logic [SW-1:0] ctl;
        logic          busy;
        logic          rev;
    } exp_t;

    vec_t vq[$];
    exp_t sbq[$];

    mux_bus_arbiter #(.N_REQ(N), .SEL_W(SW), .HOLD_MAX(HM)) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .grant    (grant),
        .controle (controle),
        .busy     (busy),
        .revoke   (revoke)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic add_vec(input logic r, input logic [N-1:0] rq,
                           input logic [N-1:0] g, input logic [SW-1:0] c,
                           input logic b);
        vec_t v;
        v.rst = r; v.req = rq; v.grant = g; v.ctl = c; v.busy = b;
        vq.push_back(v);
    endtask

    task automatic cmp(input string name, input logic [N-1:0] act,
                       input logic [N-1:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, stepno, act, want);
        end
    endtask

    // Drive one cycle of stimulus, record expectation, compare after edge.
    task automatic step(input logic r, input logic [N-1:0] rq,
                        input logic [N-1:0] g, input logic [SW-1:0] c,
                        input logic b, input logic rv);
        exp_t e;
        exp_t got;
        reset = r;
        req   = rq;
        e.grant = g; e.ctl = c; e.busy = b; e.rev = rv;
        sbq.push_back(e);
        @(posedge clock);
        #1;
        stepno++;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty step %0d", stepno);
        end else begin
            got = sbq.pop_front();
            cmp("grant",    grant,            got.grant);
            cmp("controle", N'(controle),     N'(got.ctl));
            cmp("busy",     N'(busy),         N'(got.busy));
            cmp("revoke",   N'(revoke),       N'(got.rev));
        end
    endtask

    function automatic logic [N-1:0] bit_of(input int k);
        logic [N-1:0] one;
        one = 11'h001;
        return one << k;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int owner;
        int nxt;
        int blk;
        int own_t;
        logic rv;

        reset = 1'b1;
        req   = 11'h000;
        @(posedge clock);
        #1;

        // Table: rst, req, expected grant, controle, busy (revoke always 0)
        add_vec(1'b1, 11'h000, 11'h000, 4'h0, 1'b0);   // reset state
        add_vec(1'b0, 11'h004, 11'h004, 4'h2, 1'b1);   // single requester
        add_vec(1'b0, 11'h004, 11'h004, 4'h2, 1'b1);
        add_vec(1'b0, 11'h004, 11'h004, 4'h2, 1'b1);
        add_vec(1'b0, 11'h000, 11'h000, 4'h2, 1'b0);   // release, ctl holds
        add_vec(1'b0, 11'h000, 11'h000, 4'h2, 1'b0);
        add_vec(1'b1, 11'h000, 11'h000, 4'h0, 1'b0);
        add_vec(1'b0, 11'h401, 11'h001, 4'h0, 1'b1);   // index 0 first
        add_vec(1'b0, 11'h401, 11'h001, 4'h0, 1'b1);
        add_vec(1'b0, 11'h400, 11'h400, 4'hA, 1'b1);   // gapless handover
        add_vec(1'b0, 11'h400, 11'h400, 4'hA, 1'b1);
        add_vec(1'b0, 11'h000, 11'h000, 4'hA, 1'b0);
        add_vec(1'b0, 11'h020, 11'h020, 4'h5, 1'b1);
        add_vec(1'b1, 11'h020, 11'h000, 4'h0, 1'b0);   // reset mid-grant
        add_vec(1'b0, 11'h060, 11'h020, 4'h5, 1'b1);   // pointer was reset
        add_vec(1'b0, 11'h040, 11'h040, 4'h6, 1'b1);
        add_vec(1'b0, 11'h000, 11'h000, 4'h6, 1'b0);
        add_vec(1'b0, 11'h041, 11'h001, 4'h0, 1'b1);   // wrap past 10 to 0
        add_vec(1'b0, 11'h040, 11'h040, 4'h6, 1'b1);
        add_vec(1'b0, 11'h000, 11'h000, 4'h6, 1'b0);
        add_vec(1'b0, 11'h0C0, 11'h080, 4'h7, 1'b1);   // pointer after 6
        add_vec(1'b0, 11'h000, 11'h000, 4'h7, 1'b0);
        add_vec(1'b0, 11'h7FF, 11'h100, 4'h8, 1'b1);
        add_vec(1'b0, 11'h000, 11'h000, 4'h8, 1'b0);
        add_vec(1'b0, 11'h001, 11'h001, 4'h0, 1'b1);
        add_vec(1'b0, 11'h003, 11'h001, 4'h0, 1'b1);   // no preemption
        add_vec(1'b0, 11'h002, 11'h002, 4'h1, 1'b1);
        add_vec(1'b0, 11'h000, 11'h000, 4'h1, 1'b0);

        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].req, vq[i].grant, vq[i].ctl, vq[i].busy, 1'b0);
        end

        // Rotation with all requesting: each owner drops for one cycle.
        step(1'b1, 11'h000, 11'h000, 4'h0, 1'b0, 1'b0);
        step(1'b0, 11'h7FF, 11'h001, 4'h0, 1'b1, 1'b0);
        owner = 0;
        for (int i = 0; i < 12; i++) begin
            nxt = (owner + 1) % N;
            step(1'b0, 11'h7FF & ~bit_of(owner), bit_of(nxt), SW'(nxt), 1'b1, 1'b0);
            step(1'b0, 11'h7FF, bit_of(nxt), SW'(nxt), 1'b1, 1'b0);
            owner = nxt;
        end

        // Two continuous requesters 3 and 5.
        step(1'b1, 11'h000, 11'h000, 4'h0, 1'b0, 1'b0);
        for (int j = 1; j <= 10; j++) begin
`ifdef MUX_ARB_TIMEOUT_EN
            blk   = (j - 1) / HM;
            own_t = (blk % 2 == 0) ? 3 : 5;
            rv    = (j > 1) && ((j - 1) % HM == 0);
`else
            blk   = 0;
            own_t = 3;
            rv    = 1'b0;
`endif
            step(1'b0, 11'h028, bit_of(own_t), SW'(own_t), 1'b1, rv);
        end

        // Lone requester 7: never revoked.
        step(1'b1, 11'h000, 11'h000, 4'h0, 1'b0, 1'b0);
        for (int j = 0; j < 10; j++) begin
            step(1'b0, 11'h080, 11'h080, 4'h7, 1'b1, 1'b0);
        end
        step(1'b0, 11'h000, 11'h000, 4'h7, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
